// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: segment decode table,
// SEG bit positions, all-off patterns and the slot phase type.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_t;

    localparam logic [7:0] AN_ALL_OFF  = 8'hFF;
    localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

    // SEG[7:1] = CA..CG, SEG[0] = DP
    localparam int SEG_CA_BIT = 7;
    localparam int SEG_CG_BIT = 1;
    localparam int SEG_DP_BIT = 0;

    // Active-low {CA,CB,CC,CD,CE,CF,CG}, entry 15 first
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Purpose: hex nibble to active-low {CA..CG} segment pattern.
// Latency: combinational.
// Backpressure: none.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_controller.sv
// Purpose: 8-digit multiplexed display scan with per-slot blanking and frame-aligned double buffer.
// Latency: AN/SEG registered; a load is promoted at the next frame boundary (<= 1 frame + 1 cycle).
// Backpressure: load_ready low while the pending buffer holds an unpromoted load.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int TICKS_PER_SLOT = 100_000,
    parameter int BLANK_TICKS    = 5_000
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_digits,
    input  logic [7:0]  load_dp,
    input  logic [7:0]  load_mask,
    output logic [7:0]  AN,
    output logic [7:0]  SEG,
    output logic        frame_start
);

    localparam int CW = $clog2(TICKS_PER_SLOT);
    localparam logic [CW-1:0] SLOT_LAST = CW'(TICKS_PER_SLOT - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_TICKS);

    phase_t        state, state_nxt;
    logic [CW-1:0] slot_cnt, slot_cnt_nxt;
    logic [2:0]    idx, idx_nxt;

    logic [31:0]   act_digits, pend_digits;
    logic [7:0]    act_dp, pend_dp;
    logic [7:0]    act_mask, pend_mask;
    logic          pending_full;

    logic          slot_end;
    logic          boundary;
    logic          accept;
    logic [6:0]    dec_seg;
    logic [7:0]    an_nxt, seg_nxt;

    assign slot_end   = (slot_cnt == SLOT_LAST);
    assign boundary   = slot_end && (idx == 3'd7);
    assign load_ready = ~pending_full;
    assign accept     = load_valid && load_ready;

    seg7_hex_decode u_dec (
        .nibble (act_digits[{idx, 2'b00} +: 4]),
        .seg_n  (dec_seg)
    );

    // Phase follows the value slot_cnt is about to take, so outputs switch on the entry edge
    always_comb begin
        state_nxt    = state;
        slot_cnt_nxt = slot_cnt + CW'(1);
        idx_nxt      = idx;
        if (slot_end) begin
            slot_cnt_nxt = '0;
            idx_nxt      = idx + 3'd1;
            state_nxt    = BLANK;
        end else if ((slot_cnt + CW'(1)) >= BLANK_END) begin
            state_nxt = DRIVE;
        end
    end

    // idx and the active set never change on a DRIVE-entry edge, so current values are safe here
    always_comb begin
        an_nxt  = AN_ALL_OFF;
        seg_nxt = SEG_ALL_OFF;
        if (state_nxt == DRIVE && act_mask[idx]) begin
            an_nxt                          = ~(8'd1 << idx);
            seg_nxt[SEG_CA_BIT:SEG_CG_BIT]  = dec_seg;
            seg_nxt[SEG_DP_BIT]             = ~act_dp[idx];
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state       <= BLANK;
            slot_cnt    <= '0;
            idx         <= 3'd0;
            AN          <= AN_ALL_OFF;
            SEG         <= SEG_ALL_OFF;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            slot_cnt    <= slot_cnt_nxt;
            idx         <= idx_nxt;
            AN          <= an_nxt;
            SEG         <= seg_nxt;
            frame_start <= boundary;
        end
    end

    // A load can only be accepted while empty, so promotion and capture never collide
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            act_digits   <= '0;
            act_dp       <= '0;
            act_mask     <= '0;
            pend_digits  <= '0;
            pend_dp      <= '0;
            pend_mask    <= '0;
            pending_full <= 1'b0;
        end else begin
            if (boundary && pending_full) begin
                act_digits   <= pend_digits;
                act_dp       <= pend_dp;
                act_mask     <= pend_mask;
                pending_full <= 1'b0;
            end else if (accept) begin
                pend_digits  <= load_digits;
                pend_dp      <= load_dp;
                pend_mask    <= load_mask;
                pending_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with 10-tick slots and 2-tick blanking
// (slot = 10 cycles, frame = 80 cycles, boundaries on every 80th edge after release).
module tb_seg7_scan_controller;

    logic        CLK100MHZ = 1'b0;
    logic        CPU_RESETN = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_digits = '0;
    logic [7:0]  load_dp = '0;
    logic [7:0]  load_mask = '0;
    logic [7:0]  AN;
    logic [7:0]  SEG;
    logic        frame_start;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   blank_run = 0;
    bit   seen_on = 1'b0;
    logic [7:0] last_on = 8'hFF;

    seg7_scan_controller #(
        .TICKS_PER_SLOT (10),
        .BLANK_TICKS    (2)
    ) dut (
        .CLK100MHZ   (CLK100MHZ),
        .CPU_RESETN  (CPU_RESETN),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_digits (load_digits),
        .load_dp     (load_dp),
        .load_mask   (load_mask),
        .AN          (AN),
        .SEG         (SEG),
        .frame_start (frame_start)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%02h expected=0x%02h at cyc %0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock: sample at the falling edge and check the scan invariants every cycle
    task automatic step();
        @(posedge CLK100MHZ);
        cyc++;
        @(negedge CLK100MHZ);
        chk("an_onehot", 8'($countones(~AN) <= 1), 8'd1);
        chk("frame_start", 8'(frame_start), 8'((cyc % 80) == 0));
        if (AN != 8'hFF) begin
            if (seen_on && (blank_run > 0 || AN != last_on))
                chk("blank_gap", 8'(blank_run >= 2), 8'd1);
            blank_run = 0;
            seen_on   = 1'b1;
            last_on   = AN;
        end else begin
            blank_run++;
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic drive_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] m);
        load_valid  = 1'b1;
        load_digits = d;
        load_dp     = dp;
        load_mask   = m;
    endtask

    task automatic chk_disp(input string tag, input logic [7:0] an_exp, input logic [7:0] seg_exp);
        chk({tag, "_an"}, AN, an_exp);
        chk({tag, "_seg"}, SEG, seg_exp);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge CLK100MHZ);
        chk_disp("rst", 8'hFF, 8'hFF);
        chk("rst_ready", 8'(load_ready), 8'd1);
        chk("rst_fs", 8'(frame_start), 8'd0);
        CPU_RESETN = 1'b1;
        cyc = 0;

        // Idle: dark throughout, frame_start at 80 and 160
        for (int i = 0; i < 200; i++) begin
            step();
            chk_disp("idle", 8'hFF, 8'hFF);
            chk("idle_ready", 8'(load_ready), 8'd1);
        end

        // Full-mask load, promoted at 240
        chk("s2_ready_pre", 8'(load_ready), 8'd1);
        drive_load(32'h8675_3090, 8'h00, 8'hFF);
        step();
        load_valid = 1'b0;
        chk("s2_ready_busy", 8'(load_ready), 8'd0);
        run_to(232); chk_disp("s2_prepromo", 8'hFF, 8'hFF);
        run_to(240); chk("s2_ready_promo", 8'(load_ready), 8'd1);
        run_to(241); chk_disp("s2_d0_blank", 8'hFF, 8'hFF);
        run_to(242); chk_disp("s2_d0_first", 8'hFE, 8'b0000_0011);
        run_to(249); chk_disp("s2_d0_last", 8'hFE, 8'b0000_0011);
        run_to(250); chk_disp("s2_d1_blank", 8'hFF, 8'hFF);
        run_to(252); chk_disp("s2_d1_nine", 8'hFD, 8'b0000_1001);
        run_to(312); chk_disp("s2_d7_eight", 8'h7F, 8'b0000_0001);

        // Digit 0 masked, DP on digit 3, promoted at 400
        run_to(320);
        drive_load(32'h8675_3090, 8'h08, 8'hFE);
        step();
        load_valid = 1'b0;
        run_to(402); chk_disp("s3_d0_masked", 8'hFF, 8'hFF);
        run_to(405); chk_disp("s3_d0_masked2", 8'hFF, 8'hFF);
        run_to(412); chk_disp("s3_d1", 8'hFD, 8'b0000_1001);
        run_to(432); chk_disp("s3_d3_dp", 8'hF7, 8'b0000_1100);

        // Back-to-back loads: second held until the 480 boundary
        run_to(440);
        drive_load(32'h1111_1111, 8'h00, 8'hFF);
        step();
        drive_load(32'hFFFF_FFFF, 8'h00, 8'hFF);
        chk("s4_held", 8'(load_ready), 8'd0);
        run_to(479); chk("s4_held_late", 8'(load_ready), 8'd0);
        run_to(480); chk("s4_ready_promo", 8'(load_ready), 8'd1);
        step();
        load_valid = 1'b0;
        chk("s4_second_acc", 8'(load_ready), 8'd0);
        run_to(482); chk_disp("s4_first_d0", 8'hFE, 8'b1001_1111);
        run_to(552); chk_disp("s4_first_d7", 8'h7F, 8'b1001_1111);
        run_to(560); chk("s4_ready_promo2", 8'(load_ready), 8'd1);
        run_to(562); chk_disp("s4_second_d0", 8'hFE, 8'b0111_0001);

        // Load accepted on the 640 boundary edge: shown only after 720
        run_to(639);
        chk("s5_ready_pre", 8'(load_ready), 8'd1);
        drive_load(32'hAAAA_AAAA, 8'hFF, 8'hFF);
        step();
        load_valid = 1'b0;
        chk("s5_acc_on_bnd", 8'(load_ready), 8'd0);
        run_to(642); chk_disp("s5_old_d0", 8'hFE, 8'b0111_0001);
        run_to(712); chk_disp("s5_old_d7", 8'h7F, 8'b0111_0001);
        run_to(720); chk("s5_ready_promo", 8'(load_ready), 8'd1);
        run_to(722); chk_disp("s5_new_d0", 8'hFE, 8'b0001_0000);

        // Reset mid-DRIVE with a pending load
        run_to(723);
        drive_load(32'h1234_5678, 8'h00, 8'hFF);
        step();
        load_valid = 1'b0;
        chk("s6_pending", 8'(load_ready), 8'd0);
        chk("s6_driving", AN, 8'hFE);
        #2 CPU_RESETN = 1'b0;
        #1;
        chk_disp("s6_async", 8'hFF, 8'hFF);
        chk("s6_async_ready", 8'(load_ready), 8'd1);
        chk("s6_async_fs", 8'(frame_start), 8'd0);
        repeat (2) @(negedge CLK100MHZ);
        CPU_RESETN = 1'b1;
        cyc       = 0;
        blank_run = 0;
        seen_on   = 1'b0;
        for (int i = 0; i < 90; i++) begin
            step();
            chk_disp("s6_dark", 8'hFF, 8'hFF);
            chk("s6_ready", 8'(load_ready), 8'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
